hi_rr_arbitor: RTL and testbench
================================

HI_RR_ARBITOR -- requirements
Module: hi_rr_arbitor

Interface
REQ-001 SHALL have parameter NUM_HOSTS, default 4, number of host ports; legal range 2..16.
REQ-002 SHALL have parameter RR_EN, default 1; 1 selects round-robin arbitration, 0 selects fixed priority with the lowest index winning.
REQ-003 SHALL have parameters TERM_W=16, ADDR_W=32, LEN_W=32, DATA_W=32, STAT_W=16, which set the field widths; GW = max(1, clog2(NUM_HOSTS)).
REQ-004 SHALL have ports: ifclk in 1, the single clock; reset in 1, synchronous active-high reset.
REQ-005 SHALL have per-host inputs packed as [NUM_HOSTS*W-1:0], with host k at [k*W +: W]: I_di_term_addr (TERM_W), I_di_reg_addr (ADDR_W), I_di_len (LEN_W), I_di_reg_datai (DATA_W), I_di_read_mode, I_di_read_req, I_di_read, I_di_write, I_di_write_mode (1 each).
REQ-006 SHALL have per-host outputs packed in the same way: O_di_read_rdy (1), O_di_write_rdy (1), O_di_reg_datao (DATA_W), O_di_transfer_status (STAT_W).
REQ-007 SHALL have device-side outputs di_term_addr, di_reg_addr, di_len, di_reg_datai, di_read_mode, di_read_req, di_read, di_write and di_write_mode, each at the width of its host-side field.
REQ-008 SHALL have device-side inputs di_read_rdy (1), di_write_rdy (1), di_reg_datao (DATA_W) and di_transfer_status (STAT_W).
REQ-009 SHALL have status outputs grant (GW), the current owner, and grant_valid (1), which is high only in ACTIVE.

Function
REQ-010 SHALL implement a three-state FSM (IDLE, ACTIVE, TURNAROUND) with registered state, grant and last_grant.
REQ-011 In IDLE, the block SHALL treat host k as requesting when I_di_read_mode[k] or I_di_write_mode[k] is high.
REQ-012 In IDLE with one or more hosts requesting, the block SHALL load grant at the next edge and enter ACTIVE, so the device sees the host's fields one cycle after the mode asserts.
REQ-013 With RR_EN=1, the block SHALL search upward from last_grant+1, wrapping modulo NUM_HOSTS, and grant the first requester found.
REQ-014 With RR_EN=0, the block SHALL grant the lowest-index requester.
REQ-015 In ACTIVE, all device-side outputs SHALL be combinational copies of host[grant]'s inputs.
REQ-016 In IDLE and TURNAROUND, all device-side outputs SHALL be 0.
REQ-017 In ACTIVE, host[grant] SHALL receive di_read_rdy, di_write_rdy, di_reg_datao and di_transfer_status.
REQ-018 Every non-granted host, and every host outside ACTIVE, SHALL receive 0 on all O_* outputs, which stalls it through rdy=0.
REQ-019 In ACTIVE, the FSM SHALL go to TURNAROUND at the next edge when I_di_read_mode[grant] and I_di_write_mode[grant] are both low, and SHALL load last_grant <= grant at that edge.
REQ-020 TURNAROUND SHALL last exactly 1 cycle and then go to IDLE, so the minimum gap between two hosts' ownership is 2 cycles.
REQ-021 The block SHALL keep a register pend_rd[NUM_HOSTS] in which bit k sets when I_di_read_req[k]=1 while host k is not (ACTIVE and grant==k).
REQ-022 In ACTIVE, di_read_req SHALL equal I_di_read_req[grant] OR replay.
REQ-023 replay SHALL be 1 only on the first ACTIVE cycle, and only if pend_rd[grant] was set on entry.
REQ-024 pend_rd[grant] SHALL clear at the end of the first ACTIVE cycle.
REQ-025 If a set and a clear of pend_rd[k] fall in the same cycle, the set SHALL win; this cannot occur for the granted host in ACTIVE.
REQ-026 A host whose mode drops while it is not granted SHALL keep any pend_rd bit it has until it is next granted.
REQ-027 Arbitration SHALL never pre-empt an ACTIVE transfer, whatever other requests arrive.
REQ-028 If both mode bits of a host are high at once, the block SHALL treat it as a single request and pass both bits through.
REQ-029 The block SHALL contain no combinational path from device inputs to the grant decision.

Reset
REQ-030 While reset=1 at an edge: state=IDLE, grant=0, last_grant=NUM_HOSTS-1 (so host 0 wins first under RR), pend_rd=0.
REQ-031 While reset=1, all device-side outputs, O_* outputs and grant_valid SHALL be 0 at the following cycle.
REQ-032 A reset asserted mid-transfer SHALL abort ownership at once, and SHALL drop any pending replay.

Verification
REQ-033 Scenario: NUM_HOSTS=4, RR_EN=1; hosts 0-3 hold write_mode together for 3 cycles per grant -> grant sequence 0,1,2,3,0, with each ownership separated by 1 TURNAROUND cycle plus 1 IDLE cycle.
REQ-034 Scenario: RR_EN=0, hosts 1 and 3 both requesting continuously -> host 1 granted repeatedly and host 3 never granted.
REQ-035 Scenario: host 0 ACTIVE and host 2 pulses read_req for 1 cycle with read_mode high -> host 2 sees O_di_read_rdy=0 throughout; when host 2 is later granted, di_read_req=1 for exactly its first ACTIVE cycle and pend_rd[2]=0 afterwards.
REQ-036 Scenario: host 1 ACTIVE with di_reg_datao=32'hDEADBEEF and di_read_rdy=1 -> O_di_reg_datao[1]=DEADBEEF, all other hosts' data and rdy are 0, grant=1, grant_valid=1.
REQ-037 Scenario: reset=1 asserted during an ACTIVE write on host 2 -> at the next edge grant_valid=0, di_write_mode=0, O_di_write_rdy=0 for all hosts; after reset releases, host 0 has priority.

Source files
------------

// File: rtl/hi_rr_arbitor.sv
// Shares one register-access device port among NUM_HOSTS hosts. An owner keeps the port until
// it drops both mode bits; read requests raised while a host waits are replayed once it owns the port.
module hi_rr_arbitor #(
    parameter int unsigned NUM_HOSTS = 4,
    parameter int unsigned RR_EN     = 1,
    parameter int unsigned TERM_W    = 16,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned LEN_W     = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned STAT_W    = 16,
    localparam int unsigned GW       = ($clog2(NUM_HOSTS) > 0) ? $clog2(NUM_HOSTS) : 1
) (
    input  logic                          ifclk,
    input  logic                          reset,

    input  logic [NUM_HOSTS*TERM_W-1:0]   I_di_term_addr,
    input  logic [NUM_HOSTS*ADDR_W-1:0]   I_di_reg_addr,
    input  logic [NUM_HOSTS*LEN_W-1:0]    I_di_len,
    input  logic [NUM_HOSTS*DATA_W-1:0]   I_di_reg_datai,
    input  logic [NUM_HOSTS-1:0]          I_di_read_mode,
    input  logic [NUM_HOSTS-1:0]          I_di_read_req,
    input  logic [NUM_HOSTS-1:0]          I_di_read,
    input  logic [NUM_HOSTS-1:0]          I_di_write,
    input  logic [NUM_HOSTS-1:0]          I_di_write_mode,

    output logic [NUM_HOSTS-1:0]          O_di_read_rdy,
    output logic [NUM_HOSTS-1:0]          O_di_write_rdy,
    output logic [NUM_HOSTS*DATA_W-1:0]   O_di_reg_datao,
    output logic [NUM_HOSTS*STAT_W-1:0]   O_di_transfer_status,

    output logic [TERM_W-1:0]             di_term_addr,
    output logic [ADDR_W-1:0]             di_reg_addr,
    output logic [LEN_W-1:0]              di_len,
    output logic [DATA_W-1:0]             di_reg_datai,
    output logic                          di_read_mode,
    output logic                          di_read_req,
    output logic                          di_read,
    output logic                          di_write,
    output logic                          di_write_mode,

    input  logic                          di_read_rdy,
    input  logic                          di_write_rdy,
    input  logic [DATA_W-1:0]             di_reg_datao,
    input  logic [STAT_W-1:0]             di_transfer_status,

    output logic [GW-1:0]                 grant,
    output logic                          grant_valid
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_TURN   = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [GW-1:0]        last_grant_q, last_grant_d;
    logic                 first_q, first_d;
    logic [NUM_HOSTS-1:0] pend_rd_q, pend_rd_d;

    logic [NUM_HOSTS-1:0] req_c;
    logic [NUM_HOSTS-1:0] own_c;
    logic                 owner_mode_c;
    logic                 replay_c;
    logic [GW-1:0]        lo_pick_c, hi_pick_c, pick_c;
    logic                 lo_valid_c, hi_valid_c, pick_valid_c;

    // One-hot owner decode; empty outside ACTIVE so every host-facing path is masked there.
    always_comb begin
        req_c = I_di_read_mode | I_di_write_mode;
        own_c = '0;
        for (int unsigned k = 0; k < NUM_HOSTS; k++) begin
            own_c[k] = (state_q == ST_ACTIVE) && (GW'(k) == grant_q);
        end
        owner_mode_c = |(own_c & req_c);
        replay_c     = first_q & |(own_c & pend_rd_q);
    end

    // Arbiter: descending scan leaves the lowest requester overall and the lowest one above last_grant.
    always_comb begin
        lo_pick_c  = '0;
        hi_pick_c  = '0;
        lo_valid_c = 1'b0;
        hi_valid_c = 1'b0;
        for (int k = int'(NUM_HOSTS) - 1; k >= 0; k--) begin
            if (req_c[k]) begin
                lo_pick_c  = GW'(k);
                lo_valid_c = 1'b1;
                if ((RR_EN != 0) && (GW'(k) > last_grant_q)) begin
                    hi_pick_c  = GW'(k);
                    hi_valid_c = 1'b1;
                end
            end
        end
        pick_c       = hi_valid_c ? hi_pick_c : lo_pick_c;
        pick_valid_c = lo_valid_c;
    end

    // State register.
    always_ff @(posedge ifclk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_HOSTS - 1);
            first_q      <= 1'b0;
            pend_rd_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            first_q      <= first_d;
            pend_rd_q    <= pend_rd_d;
        end
    end

    // Next-state logic; a waiting host's read_req is remembered, and set beats clear.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        first_d      = 1'b0;
        pend_rd_d    = (pend_rd_q & ~(own_c & {NUM_HOSTS{first_q}})) | (I_di_read_req & ~own_c);
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid_c) begin
                    state_d = ST_ACTIVE;
                    grant_d = pick_c;
                    first_d = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (!owner_mode_c) begin
                    state_d      = ST_TURN;
                    last_grant_d = grant_q;
                end
            end
            ST_TURN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: owner's fields forward to the device, device responses return to the owner only.
    always_comb begin
        di_term_addr         = '0;
        di_reg_addr          = '0;
        di_len               = '0;
        di_reg_datai         = '0;
        di_read_mode         = 1'b0;
        di_read_req          = 1'b0;
        di_read              = 1'b0;
        di_write             = 1'b0;
        di_write_mode        = 1'b0;
        O_di_read_rdy        = '0;
        O_di_write_rdy       = '0;
        O_di_reg_datao       = '0;
        O_di_transfer_status = '0;
        grant                = grant_q;
        grant_valid          = (state_q == ST_ACTIVE);
        for (int unsigned k = 0; k < NUM_HOSTS; k++) begin
            if (own_c[k]) begin
                di_term_addr  = I_di_term_addr[k*TERM_W +: TERM_W];
                di_reg_addr   = I_di_reg_addr[k*ADDR_W +: ADDR_W];
                di_len        = I_di_len[k*LEN_W +: LEN_W];
                di_reg_datai  = I_di_reg_datai[k*DATA_W +: DATA_W];
                di_read_mode  = I_di_read_mode[k];
                di_read_req   = I_di_read_req[k] | replay_c;
                di_read       = I_di_read[k];
                di_write      = I_di_write[k];
                di_write_mode = I_di_write_mode[k];
                O_di_read_rdy[k]                         = di_read_rdy;
                O_di_write_rdy[k]                        = di_write_rdy;
                O_di_reg_datao[k*DATA_W +: DATA_W]       = di_reg_datao;
                O_di_transfer_status[k*STAT_W +: STAT_W] = di_transfer_status;
            end
        end
    end

endmodule

// File: tb/tb_hi_rr_arbitor.sv
// Bench for hi_rr_arbitor: a round-robin and a fixed-priority instance share host stimulus and are
// compared against an ownership-level model plus directed scenarios.
module tb_hi_rr_arbitor;
    localparam int N = 4;

    logic ifclk = 1'b0;
    logic reset = 1'b1;
    always #5 ifclk = ~ifclk;

    logic [N*16-1:0] t_term;
    logic [N*32-1:0] t_addr, t_len, t_dati;
    logic [N-1:0]    t_rm, t_rq, t_rd, t_wr, t_wm;
    logic            d_rrdy, d_wrdy;
    logic [31:0]     d_dato;
    logic [15:0]     d_stat;

    logic [N-1:0]    o_rrdy, o_wrdy;
    logic [N*32-1:0] o_dato;
    logic [N*16-1:0] o_stat;
    logic [15:0]     v_term;
    logic [31:0]     v_addr, v_len, v_dati;
    logic            v_rm, v_rq, v_rd, v_wr, v_wm;
    logic [1:0]      gnt;
    logic            gv;

    logic [N-1:0]    f_rrdy, f_wrdy;
    logic [N*32-1:0] f_dato;
    logic [N*16-1:0] f_stat;
    logic [15:0]     fv_term;
    logic [31:0]     fv_addr, fv_len, fv_dati;
    logic            fv_rm, fv_rq, fv_rd, fv_wr, fv_wm;
    logic [1:0]      f_gnt;
    logic            f_gv;

    int n_cmp = 0;
    int n_bad = 0;

    hi_rr_arbitor #(.NUM_HOSTS(N), .RR_EN(1)) dut (
        .ifclk(ifclk), .reset(reset),
        .I_di_term_addr(t_term), .I_di_reg_addr(t_addr), .I_di_len(t_len), .I_di_reg_datai(t_dati),
        .I_di_read_mode(t_rm), .I_di_read_req(t_rq), .I_di_read(t_rd), .I_di_write(t_wr),
        .I_di_write_mode(t_wm),
        .O_di_read_rdy(o_rrdy), .O_di_write_rdy(o_wrdy), .O_di_reg_datao(o_dato),
        .O_di_transfer_status(o_stat),
        .di_term_addr(v_term), .di_reg_addr(v_addr), .di_len(v_len), .di_reg_datai(v_dati),
        .di_read_mode(v_rm), .di_read_req(v_rq), .di_read(v_rd), .di_write(v_wr),
        .di_write_mode(v_wm),
        .di_read_rdy(d_rrdy), .di_write_rdy(d_wrdy), .di_reg_datao(d_dato),
        .di_transfer_status(d_stat),
        .grant(gnt), .grant_valid(gv)
    );

    hi_rr_arbitor #(.NUM_HOSTS(N), .RR_EN(0)) dut_fp (
        .ifclk(ifclk), .reset(reset),
        .I_di_term_addr(t_term), .I_di_reg_addr(t_addr), .I_di_len(t_len), .I_di_reg_datai(t_dati),
        .I_di_read_mode(t_rm), .I_di_read_req(t_rq), .I_di_read(t_rd), .I_di_write(t_wr),
        .I_di_write_mode(t_wm),
        .O_di_read_rdy(f_rrdy), .O_di_write_rdy(f_wrdy), .O_di_reg_datao(f_dato),
        .O_di_transfer_status(f_stat),
        .di_term_addr(fv_term), .di_reg_addr(fv_addr), .di_len(fv_len), .di_reg_datai(fv_dati),
        .di_read_mode(fv_rm), .di_read_req(fv_rq), .di_read(fv_rd), .di_write(fv_wr),
        .di_write_mode(fv_wm),
        .di_read_rdy(d_rrdy), .di_write_rdy(d_wrdy), .di_reg_datao(d_dato),
        .di_transfer_status(d_stat),
        .grant(f_gnt), .grant_valid(f_gv)
    );

    logic [116:0] dev_act;
    logic [199:0] host_act;
    assign dev_act  = {v_term, v_addr, v_len, v_dati, v_rm, v_rq, v_rd, v_wr, v_wm};
    assign host_act = {o_rrdy, o_wrdy, o_dato, o_stat};

    // Reference model: owner index (-1 = nobody), cooldown cycles, waiting read requests.
    int           m_owner = -1, m_cool = 0, m_last = N - 1, m_gnt = 0, m_h = 0;
    logic [N-1:0] m_pend = '0;
    bit           m_first = 1'b0;
    int           p_owner = -1, p_cool = 0, p_gnt = 0;

    always @(posedge ifclk) begin
        if (reset) begin
            m_owner = -1; m_cool = 0; m_last = N - 1; m_gnt = 0; m_pend = '0; m_first = 1'b0;
            p_owner = -1; p_cool = 0; p_gnt = 0;
        end else begin
            if (m_owner >= 0 && m_first) m_pend[m_owner] = 1'b0;
            for (int k = 0; k < N; k++) if (t_rq[k] && m_owner != k) m_pend[k] = 1'b1;
            m_first = 1'b0;
            if (m_owner >= 0) begin
                if (!(t_rm[m_owner] || t_wm[m_owner])) begin
                    m_last = m_owner; m_owner = -1; m_cool = 1;
                end
            end else if (m_cool != 0) begin
                m_cool = 0;
            end else begin
                for (int i = 1; i <= N; i++) begin
                    m_h = (m_last + i) % N;
                    if (m_owner < 0 && (t_rm[m_h] || t_wm[m_h])) begin
                        m_owner = m_h; m_gnt = m_h; m_first = 1'b1;
                    end
                end
            end
            if (p_owner >= 0) begin
                if (!(t_rm[p_owner] || t_wm[p_owner])) begin p_owner = -1; p_cool = 1; end
            end else if (p_cool != 0) begin
                p_cool = 0;
            end else begin
                for (int h = 0; h < N; h++)
                    if (p_owner < 0 && (t_rm[h] || t_wm[h])) begin p_owner = h; p_gnt = h; end
            end
        end
    end

    function automatic logic [116:0] exp_dev();
        logic [116:0] e;
        e = '0;
        if (m_owner >= 0)
            e = {t_term[m_owner*16 +: 16], t_addr[m_owner*32 +: 32], t_len[m_owner*32 +: 32],
                 t_dati[m_owner*32 +: 32], t_rm[m_owner],
                 t_rq[m_owner] | (m_first & m_pend[m_owner]),
                 t_rd[m_owner], t_wr[m_owner], t_wm[m_owner]};
        return e;
    endfunction

    function automatic logic [199:0] exp_host();
        logic [N-1:0]    r, w;
        logic [N*32-1:0] dd;
        logic [N*16-1:0] ss;
        r = '0; w = '0; dd = '0; ss = '0;
        if (m_owner >= 0) begin
            r[m_owner] = d_rrdy;
            w[m_owner] = d_wrdy;
            dd[m_owner*32 +: 32] = d_dato;
            ss[m_owner*16 +: 16] = d_stat;
        end
        return {r, w, dd, ss};
    endfunction

    task automatic idle_inputs();
        t_rm = '0; t_rq = '0; t_rd = '0; t_wr = '0; t_wm = '0;
        t_term = {$urandom, $urandom};
        t_addr = {$urandom, $urandom, $urandom, $urandom};
        t_len  = {$urandom, $urandom, $urandom, $urandom};
        t_dati = {$urandom, $urandom, $urandom, $urandom};
        d_rrdy = 1'b0; d_wrdy = 1'b0; d_dato = '0; d_stat = '0;
    endtask

    task automatic pulse_reset();
        @(negedge ifclk);
        reset = 1'b1;
        idle_inputs();
        @(negedge ifclk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge ifclk);
        reset = 1'b1;
        idle_inputs();
        t_wm = '1; t_rq = '1;
        d_rrdy = 1'b1; d_wrdy = 1'b1; d_dato = $urandom; d_stat = 16'hBEEF;
        repeat (3) @(negedge ifclk);
        n_cmp++; if (gv !== 1'b0) begin n_bad++; $display("FAIL reset_grant_valid got %0b want 0", gv); end
        n_cmp++; if (gnt !== 2'd0) begin n_bad++; $display("FAIL reset_grant got %0d want 0", gnt); end
        n_cmp++; if (dev_act !== '0) begin n_bad++; $display("FAIL reset_device_outputs got %h want 0", dev_act); end
        n_cmp++; if (host_act !== '0) begin n_bad++; $display("FAIL reset_host_outputs got %h want 0", host_act); end
        n_cmp++; if (f_gv !== 1'b0) begin n_bad++; $display("FAIL reset_fp_grant_valid got %0b want 0", f_gv); end
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_rr_rotation();
        int seq[$], gaps[$], lens[$];
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        int act = 0, gap = 0;
        pulse_reset();
        t_wm = '1;
        for (int c = 0; c < 60 && seq.size() < 5; c++) begin
            @(negedge ifclk);
            if (gv === 1'b1) begin
                if (act == 0) begin
                    seq.push_back(int'(gnt));
                    if (seq.size() > 1) gaps.push_back(gap);
                end
                act++; gap = 0;
                if (act == 3) t_wm[gnt] = 1'b0;
            end else begin
                if (act != 0) lens.push_back(act);
                act = 0; gap++;
                t_wm = '1;
            end
        end
        n_cmp++;
        if (seq.size() != 5) begin
            n_bad++; $display("FAIL rr_rotation_count got %0d grants want 5", seq.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (seq[i] != exp_seq[i]) begin
                    n_bad++; $display("FAIL rr_rotation_order[%0d] got %0d want %0d", i, seq[i], exp_seq[i]);
                end
            end
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (gaps[i] != 2) begin n_bad++; $display("FAIL rr_gap[%0d] got %0d want 2", i, gaps[i]); end
                n_cmp++;
                if (lens[i] != 3) begin n_bad++; $display("FAIL rr_hold[%0d] got %0d want 3", i, lens[i]); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_fixed_priority();
        int n1 = 0, n3 = 0, act = 0, model_bad = 0;
        pulse_reset();
        t_rm[1] = 1'b1; t_rm[3] = 1'b1;
        for (int c = 0; c < 48; c++) begin
            @(negedge ifclk);
            if ((f_gv !== (p_owner >= 0)) || (f_gnt !== 2'(p_gnt))) model_bad++;
            if (f_gv === 1'b1) begin
                if (act == 0) begin
                    if (f_gnt == 2'd1) n1++;
                    if (f_gnt == 2'd3) n3++;
                end
                act++;
            end else begin
                act = 0;
            end
            t_rm[1] = !(f_gv === 1'b1 && f_gnt == 2'd1 && act == 2);
        end
        n_cmp++; if (n1 < 8) begin n_bad++; $display("FAIL fp_host1_grants got %0d want >=8", n1); end
        n_cmp++; if (n3 != 0) begin n_bad++; $display("FAIL fp_host3_grants got %0d want 0", n3); end
        n_cmp++; if (model_bad != 0) begin n_bad++; $display("FAIL fp_model_cycles got %0d bad want 0", model_bad); end
        idle_inputs();
    endtask

    task automatic test_replay();
        bit ok = 1'b0;
        int stall_bad = 0;
        pulse_reset();
        t_wm[0] = 1'b1; d_rrdy = 1'b1; d_wrdy = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge ifclk);
            if (gv === 1'b1 && gnt === 2'd0) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL replay_host0_grant timeout"); end
        t_rm[2] = 1'b1; t_rq[2] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge ifclk);
            t_rq[2] = 1'b0;
            if (o_rrdy[2] !== 1'b0) stall_bad++;
        end
        n_cmp++; if (o_rrdy[0] !== 1'b1) begin n_bad++; $display("FAIL replay_owner_rdy got %0b want 1", o_rrdy[0]); end
        t_wm[0] = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge ifclk);
            if (gv === 1'b1 && gnt === 2'd2) begin ok = 1'b1; break; end
            if (o_rrdy[2] !== 1'b0) stall_bad++;
        end
        n_cmp++; if (stall_bad != 0) begin n_bad++; $display("FAIL replay_waiter_stalled got %0d rdy cycles want 0", stall_bad); end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL replay_host2_grant timeout"); end
        n_cmp++; if (v_rq !== 1'b1) begin n_bad++; $display("FAIL replay_first_cycle got %0b want 1", v_rq); end
        n_cmp++; if (o_rrdy[2] !== 1'b1) begin n_bad++; $display("FAIL replay_grant_rdy got %0b want 1", o_rrdy[2]); end
        @(negedge ifclk);
        n_cmp++; if (v_rq !== 1'b0) begin n_bad++; $display("FAIL replay_second_cycle got %0b want 0", v_rq); end
        t_rm[2] = 1'b0;
        repeat (3) @(negedge ifclk);
        t_rm[2] = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge ifclk);
            if (gv === 1'b1 && gnt === 2'd2) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok || v_rq !== 1'b0) begin n_bad++; $display("FAIL replay_cleared got %0b ok %0b want 0", v_rq, ok); end
        idle_inputs();
    endtask

    task automatic test_data_route();
        bit ok = 1'b0;
        logic [N*32-1:0] other;
        logic [N*16-1:0] es;
        pulse_reset();
        t_rm[1] = 1'b1;
        d_dato = 32'hDEADBEEF; d_rrdy = 1'b1; d_wrdy = 1'b0; d_stat = 16'($urandom);
        for (int c = 0; c < 10; c++) begin
            @(negedge ifclk);
            if (gv === 1'b1) begin ok = 1'b1; break; end
        end
        other = o_dato; other[63:32] = '0;
        es = '0; es[31:16] = d_stat;
        n_cmp++; if (!ok || gnt !== 2'd1) begin n_bad++; $display("FAIL route_grant got %0d want 1", gnt); end
        n_cmp++; if (o_dato[63:32] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL route_data got %h want deadbeef", o_dato[63:32]); end
        n_cmp++; if (other !== '0) begin n_bad++; $display("FAIL route_other_data got %h want 0", other); end
        n_cmp++; if (o_rrdy !== 4'b0010) begin n_bad++; $display("FAIL route_rdy got %b want 0010", o_rrdy); end
        n_cmp++; if (o_stat !== es) begin n_bad++; $display("FAIL route_status got %h want %h", o_stat, es); end
        n_cmp++; if (v_addr !== t_addr[63:32] || v_rm !== 1'b1) begin
            n_bad++; $display("FAIL route_device_fields got %h/%0b want %h/1", v_addr, v_rm, t_addr[63:32]);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        bit ok = 1'b0;
        pulse_reset();
        t_wm[2] = 1'b1; d_wrdy = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge ifclk);
            if (gv === 1'b1 && gnt === 2'd2) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL midreset_grant timeout"); end
        t_rm[3] = 1'b1; t_rq[3] = 1'b1;
        @(negedge ifclk);
        t_rq[3] = 1'b0;
        n_cmp++; if (o_wrdy !== 4'b0100) begin n_bad++; $display("FAIL midreset_wrdy_before got %b want 0100", o_wrdy); end
        reset = 1'b1;
        @(negedge ifclk);
        n_cmp++; if (gv !== 1'b0 || v_wm !== 1'b0) begin n_bad++; $display("FAIL midreset_abort got gv %0b wm %0b want 0", gv, v_wm); end
        n_cmp++; if (o_wrdy !== '0) begin n_bad++; $display("FAIL midreset_wrdy got %b want 0", o_wrdy); end
        reset = 1'b0;
        t_rm = '0; t_wm = '1;
        @(negedge ifclk);
        n_cmp++; if (gv !== 1'b1 || gnt !== 2'd0) begin n_bad++; $display("FAIL midreset_first_owner got %0b/%0d want 1/0", gv, gnt); end
        t_wm = 4'b1000;
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge ifclk);
            if (gv === 1'b1 && gnt === 2'd3) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok || v_rq !== 1'b0) begin n_bad++; $display("FAIL midreset_replay_dropped got %0b ok %0b want 0", v_rq, ok); end
        idle_inputs();
    endtask

    task automatic test_random();
        pulse_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge ifclk);
            n_cmp++;
            if (dev_act !== exp_dev()) begin n_bad++; $display("FAIL rand_device c%0d got %h want %h", c, dev_act, exp_dev()); end
            n_cmp++;
            if (host_act !== exp_host()) begin n_bad++; $display("FAIL rand_host c%0d got %h want %h", c, host_act, exp_host()); end
            n_cmp++;
            if (gv !== (m_owner >= 0) || gnt !== 2'(m_gnt)) begin
                n_bad++; $display("FAIL rand_grant c%0d got %0b/%0d want %0b/%0d", c, gv, gnt, m_owner >= 0, m_gnt);
            end
            n_cmp++;
            if (f_gv !== (p_owner >= 0) || f_gnt !== 2'(p_gnt)) begin
                n_bad++; $display("FAIL rand_fp_grant c%0d got %0b/%0d want %0b/%0d", c, f_gv, f_gnt, p_owner >= 0, p_gnt);
            end
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 5) == 0) begin
                    t_rm[k] = 1'($urandom_range(0, 1));
                    t_wm[k] = 1'($urandom_range(0, 1));
                end
            end
            t_rq = 4'($urandom) & 4'($urandom);
            t_rd = 4'($urandom); t_wr = 4'($urandom);
            t_term = {$urandom, $urandom};
            t_addr = {$urandom, $urandom, $urandom, $urandom};
            t_len  = {$urandom, $urandom, $urandom, $urandom};
            t_dati = {$urandom, $urandom, $urandom, $urandom};
            d_rrdy = 1'($urandom_range(0, 1)); d_wrdy = 1'($urandom_range(0, 1));
            d_dato = $urandom; d_stat = 16'($urandom);
            reset = ($urandom_range(0, 299) == 0);
        end
        @(negedge ifclk);
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_rr_rotation();
        test_fixed_priority();
        test_replay();
        test_data_route();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
